ibex_return_addr_stack: RTL



---
 rtl/ibex_pkg.sv | 17 +
 rtl/ibex_return_addr_stack.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/ibex_pkg.sv
// Shared types for the Ibex return-address (shadow) stack.
// Error causes and overflow policies used by the stack and its environment.
package ibex_pkg;

    typedef enum logic [1:0] {
        SS_ERR_NONE      = 2'd0,
        SS_ERR_OVERFLOW  = 2'd1,
        SS_ERR_UNDERFLOW = 2'd2,
        SS_ERR_MISMATCH  = 2'd3
    } ss_err_e;

    typedef enum logic {
        SS_OVF_ERROR = 1'b0,
        SS_OVF_WRAP  = 1'b1
    } ss_ovf_mode_e;

endpackage

// File: rtl/ibex_return_addr_stack.sv
// Hardware return-address stack: calls push the link address, returns pop and
// compare against the real return target. Errors pulse for one cycle and latch a sticky cause.
module ibex_return_addr_stack
    import ibex_pkg::*;
#(
    parameter int unsigned  Width   = 32,
    parameter int unsigned  Depth   = 16,
    parameter ss_ovf_mode_e OvfMode = SS_OVF_ERROR
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [Width-1:0]           push_addr_i,
    input  logic                       pop_i,
    input  logic [Width-1:0]           pop_addr_i,
    input  logic                       flush_i,
    input  logic                       err_clr_i,
    output logic                       err_o,
    output ss_err_e                    err_cause_o,
    output logic                       err_sticky_o,
    output logic [$clog2(Depth+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam int unsigned PtrW = $clog2(Depth);

    localparam logic [PtrW-1:0] PtrLast = PtrW'(Depth - 1);
    localparam logic [CntW-1:0] CntFull = CntW'(Depth);

    logic [Width-1:0] mem [Depth];

    logic [PtrW-1:0] top_q, top_d, ptr_inc, ptr_dec, wr_ptr;
    logic [CntW-1:0] count_q, count_d;
    logic            discarded_q, discarded_d;
    logic            wr_en;
    logic            empty, full, top_mismatch;
    ss_err_e         evt;

    logic            err_q;
    ss_err_e         cause_q;
    logic            sticky_q;

    assign empty        = (count_q == '0);
    assign full         = (count_q == CntFull);
    assign top_mismatch = (mem[top_q] != pop_addr_i);

    // Explicit modulo-Depth stepping so non-power-of-two depths wrap correctly.
    assign ptr_inc = (top_q == PtrLast) ? '0 : top_q + PtrW'(1);
    assign ptr_dec = (top_q == '0) ? PtrLast : top_q - PtrW'(1);

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        top_d       = top_q;
        count_d     = count_q;
        discarded_d = discarded_q;
        wr_en       = 1'b0;
        wr_ptr      = top_q;
        evt         = SS_ERR_NONE;

        if (flush_i) begin
            count_d     = '0;
            discarded_d = 1'b0;
        end else if (push_i && pop_i) begin
            if (!empty) begin
                // Tail call: check the current top, then replace it in place.
                if (top_mismatch) begin
                    evt = SS_ERR_MISMATCH;
                end
                wr_en = 1'b1;
            end else begin
                if (!discarded_q) begin
                    evt = SS_ERR_UNDERFLOW;
                end
                top_d   = ptr_inc;
                wr_ptr  = ptr_inc;
                wr_en   = 1'b1;
                count_d = CntW'(1);
            end
        end else if (push_i) begin
            if (!full) begin
                top_d   = ptr_inc;
                wr_ptr  = ptr_inc;
                wr_en   = 1'b1;
                count_d = count_q + CntW'(1);
            end else if (OvfMode == SS_OVF_WRAP) begin
                // The slot after top holds the oldest entry; it is overwritten.
                top_d       = ptr_inc;
                wr_ptr      = ptr_inc;
                wr_en       = 1'b1;
                discarded_d = 1'b1;
            end else begin
                evt = SS_ERR_OVERFLOW;
            end
        end else if (pop_i) begin
            if (!empty) begin
                if (top_mismatch) begin
                    evt = SS_ERR_MISMATCH;
                end
                top_d   = ptr_dec;
                count_d = count_q - CntW'(1);
            end else if (!discarded_q) begin
                evt = SS_ERR_UNDERFLOW;
            end
        end
    end

    // NOTE: the entry array has no reset; count_q alone decides which entries are valid.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_addr_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            top_q       <= '0;
            count_q     <= '0;
            discarded_q <= 1'b0;
        end else begin
            top_q       <= top_d;
            count_q     <= count_d;
            discarded_q <= discarded_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_q    <= 1'b0;
            cause_q  <= SS_ERR_NONE;
            sticky_q <= 1'b0;
        end else begin
            err_q <= (evt != SS_ERR_NONE);
            // A new event in the clearing cycle becomes the fresh sticky cause.
            if ((evt != SS_ERR_NONE) && (!sticky_q || err_clr_i)) begin
                sticky_q <= 1'b1;
                cause_q  <= evt;
            end else if (err_clr_i) begin
                sticky_q <= 1'b0;
                cause_q  <= SS_ERR_NONE;
            end
        end
    end

    assign err_o        = err_q;
    assign err_cause_o  = cause_q;
    assign err_sticky_o = sticky_q;
    assign count_o      = count_q;
    assign full_o       = full;
    assign empty_o      = empty;

endmodule
